lsu_pipe: RTL and testbench

LSU_PIPE -- requirements
Module: lsu_pipe

---
 rtl/lsu_pkg.sv | 27 ++
 rtl/lsu_align.sv | 89 ++++++++
 rtl/lsu_pipe.sv | 170 +++++++++++++++++
 tb/tb_lsu_pipe.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: FSM state encoding and the
// RISC-V load/store funct3 encodings.
package lsu_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StReq,
        StWait,
        StDone
    } lsu_state_e;

    // Load funct3 encodings
    localparam logic [2:0] F3Lb  = 3'b000;
    localparam logic [2:0] F3Lh  = 3'b001;
    localparam logic [2:0] F3Lw  = 3'b010;
    localparam logic [2:0] F3Ld  = 3'b011;
    localparam logic [2:0] F3Lbu = 3'b100;
    localparam logic [2:0] F3Lhu = 3'b101;
    localparam logic [2:0] F3Lwu = 3'b110;

    // Store funct3 encodings
    localparam logic [2:0] F3Sb  = 3'b000;
    localparam logic [2:0] F3Sh  = 3'b001;
    localparam logic [2:0] F3Sw  = 3'b010;
    localparam logic [2:0] F3Sd  = 3'b011;

endpackage

// File: rtl/lsu_align.sv
// Combinational byte-lane logic for the LSU.
//   we_i, funct3_i, offset_i : access kind, size and byte offset in the word
//   wdata_i / rdata_i        : unshifted store data / raw memory read data
//   wstrb_o, wdata_o         : store strobes and data moved to the byte lane
//   rdata_o                  : load data shifted down and sign/zero extended
//   err_o                    : misaligned or illegal access
module lsu_align
    import lsu_pkg::*;
#(
    parameter int unsigned XLEN = 32
) (
    input  logic                          we_i,
    input  logic [2:0]                    funct3_i,
    input  logic [$clog2(XLEN/8)-1:0]     offset_i,
    input  logic [XLEN-1:0]               wdata_i,
    input  logic [XLEN-1:0]               rdata_i,
    output logic [XLEN/8-1:0]             wstrb_o,
    output logic [XLEN-1:0]               wdata_o,
    output logic [XLEN-1:0]               rdata_o,
    output logic                          err_o
);

    localparam int unsigned NB = XLEN / 8;
    localparam int unsigned OW = $clog2(NB);

    logic [1:0]      size;
    logic [OW+2:0]   shamt;
    logic [3:0]      off_ext;
    logic            misaligned;
    logic            illegal;
    logic [7:0]      base8;
    logic [XLEN-1:0] sh;
    int unsigned     nbits;
    logic            top;

    assign size    = funct3_i[1:0];
    assign shamt   = {offset_i, 3'b000};
    assign off_ext = 4'(offset_i);

    always_comb begin
        misaligned = 1'b0;
        case (size)
            2'd0:    misaligned = 1'b0;
            2'd1:    misaligned = off_ext[0];
            2'd2:    misaligned = |off_ext[1:0];
            default: misaligned = |off_ext[2:0];
        endcase

        illegal = (funct3_i == 3'b111);
        // Stores only exist for funct3 000..011
        if (we_i && funct3_i[2]) illegal = 1'b1;
        // LD/SD share 011; LD, SD and LWU need a 64-bit datapath
        if (XLEN == 32 && (funct3_i == F3Ld || funct3_i == F3Lwu)) illegal = 1'b1;
    end

    assign err_o = illegal | misaligned;

    always_comb begin
        base8 = 8'h01;
        case (size)
            2'd0:    base8 = 8'h01;
            2'd1:    base8 = 8'h03;
            2'd2:    base8 = 8'h0F;
            default: base8 = 8'hFF;
        endcase
    end

    assign wstrb_o = we_i ? (NB'(base8) << offset_i) : '0;
    assign wdata_o = we_i ? (wdata_i << shamt) : '0;

    assign sh = rdata_i >> shamt;

    always_comb begin
        nbits = XLEN;
        top   = sh[XLEN-1];
        case (size)
            2'd0:    begin nbits = 8;    top = sh[7];      end
            2'd1:    begin nbits = 16;   top = sh[15];     end
            2'd2:    begin nbits = 32;   top = sh[31];     end
            default: begin nbits = XLEN; top = sh[XLEN-1]; end
        endcase
        rdata_o = '0;
        // funct3[2] marks the unsigned loads
        for (int unsigned i = 0; i < XLEN; i++) begin
            rdata_o[i] = (i < nbits) ? sh[i] : (top & ~funct3_i[2]);
        end
    end

endmodule

// File: rtl/lsu_pipe.sv
// Single-outstanding load/store unit between the CPU pipeline and a
// gnt/rvalid memory port.
//   clk, rst (sync, active low)
//   req_*      : CPU access request, req_ready high only in IDLE
//   flush      : cancels the outstanding access / pending response
//   resp_*     : one-cycle response with extended load data or error
//   stall      : pipeline hold request
//   mem_*      : word-aligned memory request, strobes and read return
module lsu_pipe
    import lsu_pkg::*;
#(
    parameter int unsigned XLEN   = 32,
    parameter int unsigned ADDR_W = 32
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                req_valid,
    output logic                req_ready,
    input  logic                req_we,
    input  logic [2:0]          req_funct3,
    input  logic [ADDR_W-1:0]   req_addr,
    input  logic [XLEN-1:0]     req_wdata,
    input  logic [4:0]          req_rd,
    input  logic                flush,
    output logic                resp_valid,
    output logic [XLEN-1:0]     resp_rdata,
    output logic [4:0]          resp_rd,
    output logic                resp_err,
    output logic                stall,
    output logic                mem_req,
    output logic                mem_we,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic [XLEN/8-1:0]   mem_wstrb,
    output logic [XLEN-1:0]     mem_wdata,
    input  logic                mem_gnt,
    input  logic                mem_rvalid,
    input  logic [XLEN-1:0]     mem_rdata
);

    localparam int unsigned NB = XLEN / 8;
    localparam int unsigned OW = $clog2(NB);

    lsu_state_e          state_q, state_d;
    logic                we_q, we_d;
    logic [2:0]          funct3_q, funct3_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [XLEN-1:0]     wdata_q, wdata_d;
    logic [XLEN-1:0]     rdata_q, rdata_d;
    logic [4:0]          rd_q, rd_d;
    logic                err_q, err_d;
    logic                kill_q, kill_d;   // flushed after gnt: finish quietly

    logic                idle;
    logic                accept;
    logic                al_we;
    logic [2:0]          al_funct3;
    logic [OW-1:0]       al_off;
    logic [XLEN-1:0]     al_wdata_in;
    logic [NB-1:0]       al_wstrb;
    logic [XLEN-1:0]     al_wdata;
    logic [XLEN-1:0]     al_rdata;
    logic                al_err;

    assign idle   = (state_q == StIdle);
    assign accept = req_valid && req_ready;

    // In IDLE the aligner checks the incoming request; afterwards it works
    // on the latched one.
    assign al_we       = idle ? req_we : we_q;
    assign al_funct3   = idle ? req_funct3 : funct3_q;
    assign al_off      = idle ? req_addr[OW-1:0] : addr_q[OW-1:0];
    assign al_wdata_in = idle ? req_wdata : wdata_q;

    lsu_align #(
        .XLEN (XLEN)
    ) u_align (
        .we_i     (al_we),
        .funct3_i (al_funct3),
        .offset_i (al_off),
        .wdata_i  (al_wdata_in),
        .rdata_i  (mem_rdata),
        .wstrb_o  (al_wstrb),
        .wdata_o  (al_wdata),
        .rdata_o  (al_rdata),
        .err_o    (al_err)
    );

    always_comb begin
        state_d  = state_q;
        we_d     = we_q;
        funct3_d = funct3_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        rdata_d  = rdata_q;
        rd_d     = rd_q;
        err_d    = err_q;
        kill_d   = kill_q;
        case (state_q)
            StIdle: begin
                if (accept) begin
                    we_d     = req_we;
                    funct3_d = req_funct3;
                    addr_d   = req_addr;
                    wdata_d  = req_wdata;
                    rd_d     = req_rd;
                    err_d    = al_err;
                    kill_d   = 1'b0;
                    rdata_d  = '0;
                    state_d  = al_err ? StDone : StReq;
                end
            end
            StReq: begin
                if (mem_gnt) begin
                    state_d = we_q ? StDone : StWait;
                    if (flush) kill_d = 1'b1;
                end else if (flush) begin
                    state_d = StIdle;
                end
            end
            StWait: begin
                if (flush) kill_d = 1'b1;
                if (mem_rvalid) begin
                    rdata_d = al_rdata;
                    state_d = StDone;
                end
            end
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q  <= StIdle;
            we_q     <= 1'b0;
            funct3_q <= '0;
            addr_q   <= '0;
            wdata_q  <= '0;
            rdata_q  <= '0;
            rd_q     <= '0;
            err_q    <= 1'b0;
            kill_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            we_q     <= we_d;
            funct3_q <= funct3_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            rdata_q  <= rdata_d;
            rd_q     <= rd_d;
            err_q    <= err_d;
            kill_q   <= kill_d;
        end
    end

    // All outputs are held at zero while reset is low.
    assign req_ready  = rst && idle && !flush;
    assign mem_req    = rst && (state_q == StReq);
    assign mem_we     = mem_req && we_q;
    assign mem_addr   = mem_req ? {addr_q[ADDR_W-1:OW], {OW{1'b0}}} : '0;
    assign mem_wstrb  = mem_req ? al_wstrb : '0;
    assign mem_wdata  = mem_req ? al_wdata : '0;
    assign resp_valid = rst && (state_q == StDone) && !kill_q && !flush;
    assign resp_rdata = (resp_valid && !err_q) ? rdata_q : '0;
    assign resp_rd    = resp_valid ? rd_q : '0;
    assign resp_err   = resp_valid && err_q;
    assign stall      = rst && ((state_q == StReq) || (state_q == StWait) ||
                                (req_valid && !req_ready));

endmodule

// File: tb/tb_lsu_pipe.sv
// Directed bench for lsu_pipe: an XLEN=32 and an XLEN=64 instance share the
// request and memory stimulus; expected values are hand computed.
module tb_lsu_pipe;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, req_valid, req_we, flush, mem_gnt, mem_rvalid;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr;
    logic [63:0] req_wdata, mem_rdata;
    logic [4:0]  req_rd;

    logic        a_req_ready, a_resp_valid, a_resp_err, a_stall, a_mem_req, a_mem_we;
    logic [31:0] a_resp_rdata, a_mem_addr, a_mem_wdata;
    logic [4:0]  a_resp_rd;
    logic [3:0]  a_mem_wstrb;

    logic        b_req_ready, b_resp_valid, b_resp_err, b_stall, b_mem_req, b_mem_we;
    logic [63:0] b_resp_rdata, b_mem_wdata;
    logic [31:0] b_mem_addr;
    logic [4:0]  b_resp_rd;
    logic [7:0]  b_mem_wstrb;

    lsu_pipe #(.XLEN(32), .ADDR_W(32)) dut32 (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(a_req_ready),
        .req_we(req_we), .req_funct3(req_funct3), .req_addr(req_addr),
        .req_wdata(req_wdata[31:0]), .req_rd(req_rd), .flush(flush),
        .resp_valid(a_resp_valid), .resp_rdata(a_resp_rdata), .resp_rd(a_resp_rd),
        .resp_err(a_resp_err), .stall(a_stall), .mem_req(a_mem_req), .mem_we(a_mem_we),
        .mem_addr(a_mem_addr), .mem_wstrb(a_mem_wstrb), .mem_wdata(a_mem_wdata),
        .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata[31:0])
    );

    lsu_pipe #(.XLEN(64), .ADDR_W(32)) dut64 (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(b_req_ready),
        .req_we(req_we), .req_funct3(req_funct3), .req_addr(req_addr),
        .req_wdata(req_wdata), .req_rd(req_rd), .flush(flush),
        .resp_valid(b_resp_valid), .resp_rdata(b_resp_rdata), .resp_rd(b_resp_rd),
        .resp_err(b_resp_err), .stall(b_stall), .mem_req(b_mem_req), .mem_we(b_mem_we),
        .mem_addr(b_mem_addr), .mem_wstrb(b_mem_wstrb), .mem_wdata(b_mem_wdata),
        .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata)
    );

    int checks = 0;
    int errors = 0;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Per-access observations
    logic        got_a, got_b, err_a, err_b, seen_req, cap_we;
    int          lat_a, lat_b;
    logic [31:0] rdata_a, cap_addr, cap_wdata;
    logic [63:0] rdata_b;
    logic [4:0]  rd_a;
    logic [3:0]  cap_strb;
    logic        mreq_c [0:9];
    logic        rdy_c  [0:9];
    logic        stall_c[0:9];

    // One access; cycle i=1 is the first cycle after acceptance. gnt/rvalid
    // are high from cycles gnt_from/rv_from, flush in cycle flush_at, reset
    // low in cycles rst_at and rst_at+1 (0 disables).
    task automatic access(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                          input logic [63:0] wd, input logic [63:0] rdd, input logic [4:0] rd,
                          input int gnt_from, input int rv_from, input int flush_at,
                          input int rst_at);
        got_a = 0; got_b = 0; lat_a = 0; lat_b = 0; err_a = 0; err_b = 0;
        rdata_a = '0; rdata_b = '0; rd_a = '0; seen_req = 0;
        cap_addr = '0; cap_wdata = '0; cap_strb = '0; cap_we = 0;
        for (int k = 0; k < 10; k++) begin
            mreq_c[k] = 0; rdy_c[k] = 0; stall_c[k] = 0;
        end
        @(posedge clk); #1;
        req_valid = 1; req_we = we; req_funct3 = f3; req_addr = addr;
        req_wdata = wd; req_rd = rd; mem_rdata = rdd;
        mem_gnt = 0; mem_rvalid = 0; flush = 0; rst = 1;
        #1;
        rdy_c[0] = a_req_ready;
        for (int i = 1; i <= 8; i++) begin
            if (got_a && got_b) break;
            @(posedge clk); #1;
            req_valid  = 0;
            flush      = (i == flush_at);
            mem_gnt    = (i >= gnt_from);
            mem_rvalid = (i >= rv_from);
            rst        = !(rst_at != 0 && i >= rst_at && i < rst_at + 2);
            #1;
            mreq_c[i] = a_mem_req; rdy_c[i] = a_req_ready; stall_c[i] = a_stall;
            if (a_mem_req) begin
                seen_req = 1; cap_addr = a_mem_addr; cap_strb = a_mem_wstrb;
                cap_wdata = a_mem_wdata; cap_we = a_mem_we;
            end
            if (a_resp_valid && !got_a) begin
                got_a = 1; lat_a = i; rdata_a = a_resp_rdata; err_a = a_resp_err;
                rd_a = a_resp_rd;
            end
            if (b_resp_valid && !got_b) begin
                got_b = 1; lat_b = i; rdata_b = b_resp_rdata; err_b = b_resp_err;
            end
        end
        flush = 0; mem_gnt = 0; mem_rvalid = 0; rst = 1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: bench time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 0; req_valid = 1; req_we = 0; req_funct3 = 3'b010; req_addr = 32'h100;
        req_wdata = '0; req_rd = 5'd1; flush = 0; mem_gnt = 1; mem_rvalid = 1;
        mem_rdata = '0;

        // Reset: outputs forced low even with a pending request
        @(posedge clk); @(posedge clk); #1;
        check_eq("rst_ready", a_req_ready, 0);
        check_eq("rst_stall", a_stall, 0);
        check_eq("rst_memreq", a_mem_req, 0);
        check_eq("rst_resp", a_resp_valid, 0);
        rst = 1; req_valid = 0; mem_gnt = 0; mem_rvalid = 0;
        #1;
        check_eq("idle_ready", a_req_ready, 1);
        check_eq("idle_stall", a_stall, 0);

        // SW 0x104 with immediate gnt
        access(1, 3'b010, 32'h104, 64'hDEAD_BEEF, 64'h0, 5'd3, 1, 1, 0, 0);
        check_eq("sw_ready0", rdy_c[0], 1);
        check_eq("sw_strb", cap_strb, 4'b1111);
        check_eq("sw_addr", cap_addr, 32'h104);
        check_eq("sw_wdata", cap_wdata, 32'hDEAD_BEEF);
        check_eq("sw_we", cap_we, 1);
        check_eq("sw_lat", lat_a, 2);
        check_eq("sw_rdata", rdata_a, 0);
        check_eq("sw_rd", rd_a, 5'd3);

        // LB 0x103 sign extended
        access(0, 3'b000, 32'h103, 64'h0, 64'h0000_0000_8000_0000, 5'd7, 1, 1, 0, 0);
        check_eq("lb_rdata", rdata_a, 32'hFFFF_FF80);
        check_eq("lb_rdata64", rdata_b, 64'hFFFF_FFFF_FFFF_FF80);
        check_eq("lb_lat", lat_a, 3);
        check_eq("lb_rd", rd_a, 5'd7);
        check_eq("lb_addr", cap_addr, 32'h100);
        check_eq("lb_strb", cap_strb, 4'b0000);
        check_eq("lb_stall_req", stall_c[1], 1);
        check_eq("lb_stall_wait", stall_c[2], 1);
        check_eq("lb_stall_done", stall_c[3], 0);

        // LBU 0x103 zero extended
        access(0, 3'b100, 32'h103, 64'h0, 64'h0000_0000_8000_0000, 5'd8, 1, 1, 0, 0);
        check_eq("lbu_rdata", rdata_a, 32'h0000_0080);

        // SH 0x101 misaligned
        access(1, 3'b001, 32'h101, 64'h1234, 64'h0, 5'd2, 1, 1, 0, 0);
        check_eq("sh_err", err_a, 1);
        check_eq("sh_lat", lat_a, 1);
        check_eq("sh_memreq", seen_req, 0);
        check_eq("sh_rdata", rdata_a, 0);

        // LD 0x8: illegal on 32-bit, full doubleword on 64-bit
        access(0, 3'b011, 32'h8, 64'h0, 64'h1122_3344_5566_7788, 5'd9, 1, 1, 0, 0);
        check_eq("ld32_err", err_a, 1);
        check_eq("ld32_lat", lat_a, 1);
        check_eq("ld64_err", err_b, 0);
        check_eq("ld64_rdata", rdata_b, 64'h1122_3344_5566_7788);
        check_eq("ld64_lat", lat_b, 3);

        // SB 0x102 lane placement
        access(1, 3'b000, 32'h102, 64'h1234_56AB, 64'h0, 5'd4, 1, 1, 0, 0);
        check_eq("sb_strb", cap_strb, 4'b0100);
        check_eq("sb_wdata", cap_wdata, 32'h56AB_0000);

        // LH / LHU 0x102
        access(0, 3'b001, 32'h102, 64'h0, 64'h0000_0000_8001_1234, 5'd5, 1, 1, 0, 0);
        check_eq("lh_rdata", rdata_a, 32'hFFFF_8001);
        check_eq("lh_rdata64", rdata_b, 64'hFFFF_FFFF_FFFF_8001);
        access(0, 3'b101, 32'h102, 64'h0, 64'h0000_0000_8001_1234, 5'd5, 1, 1, 0, 0);
        check_eq("lhu_rdata", rdata_a, 32'h0000_8001);

        // LW / LWU 0x100
        access(0, 3'b010, 32'h100, 64'h0, 64'h0000_0000_8765_4321, 5'd6, 1, 1, 0, 0);
        check_eq("lw_rdata", rdata_a, 32'h8765_4321);
        check_eq("lw_rdata64", rdata_b, 64'hFFFF_FFFF_8765_4321);
        access(0, 3'b110, 32'h100, 64'h0, 64'h0000_0000_8765_4321, 5'd6, 1, 1, 0, 0);
        check_eq("lwu32_err", err_a, 1);
        check_eq("lwu64_rdata", rdata_b, 64'h0000_0000_8765_4321);

        // funct3 111 is always illegal
        access(0, 3'b111, 32'h100, 64'h0, 64'h0, 5'd1, 1, 1, 0, 0);
        check_eq("f7_err32", err_a, 1);
        check_eq("f7_err64", err_b, 1);

        // Flush in REQ with gnt withheld 5 cycles, flush in cycle 3
        access(0, 3'b010, 32'h200, 64'h0, 64'h55, 5'd10, 6, 1, 3, 0);
        check_eq("flreq_memreq3", mreq_c[3], 1);
        check_eq("flreq_memreq4", mreq_c[4], 0);
        check_eq("flreq_ready4", rdy_c[4], 1);
        check_eq("flreq_resp", got_a, 0);

        // Flush in REQ together with gnt: handshake completes, no response
        access(0, 3'b010, 32'h200, 64'h0, 64'h55, 5'd11, 1, 1, 1, 0);
        check_eq("flgnt_wait", stall_c[2], 1);
        check_eq("flgnt_resp", got_a, 0);
        check_eq("flgnt_ready4", rdy_c[4], 1);

        // Flush in DONE suppresses the response
        access(0, 3'b010, 32'h200, 64'h0, 64'h55, 5'd12, 1, 1, 3, 0);
        check_eq("fldone_resp", got_a, 0);
        check_eq("fldone_ready4", rdy_c[4], 1);

        // Reset held 2 cycles in WAIT, then rvalid
        access(0, 3'b010, 32'h200, 64'h0, 64'h55, 5'd13, 1, 4, 0, 2);
        check_eq("rstw_stall2", stall_c[2], 0);
        check_eq("rstw_ready3", rdy_c[3], 0);
        check_eq("rstw_ready4", rdy_c[4], 1);
        check_eq("rstw_ready5", rdy_c[5], 1);
        check_eq("rstw_resp", got_a, 0);

        // Flush in IDLE blocks acceptance
        @(posedge clk); #1;
        req_valid = 1; req_we = 0; req_funct3 = 3'b010; req_addr = 32'h300; flush = 1;
        #1;
        check_eq("flidle_ready", a_req_ready, 0);
        @(posedge clk); #1;
        req_valid = 0; flush = 0;
        #1;
        check_eq("flidle_memreq", a_mem_req, 0);
        check_eq("flidle_ready_after", a_req_ready, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
